// File: rtl/riscv_pkg.sv
// Shared definitions for the RV64 multicycle control: opcodes, branch
// funct3 codes, datapath select encodings and FSM state encodings.
package riscv_pkg;

    // Major opcodes handled by the control unit
    localparam logic [6:0] OP_LW      = 7'b0000011;
    localparam logic [6:0] OP_SW      = 7'b0100011;
    localparam logic [6:0] OP_ADD_SUB = 7'b0110011;
    localparam logic [6:0] OP_ADDI    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;

    // Branch funct3 codes
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Next-PC source
    localparam logic [1:0] SEL_PC_MAIS4 = 2'd0;
    localparam logic [1:0] SEL_PC_IMM   = 2'd1;
    localparam logic [1:0] SEL_PC_ULA   = 2'd2;

    // Register-file write-back source
    localparam logic [1:0] SEL_WB_ULA = 2'd0;
    localparam logic [1:0] SEL_WB_MEM = 2'd1;
    localparam logic [1:0] SEL_WB_PC4 = 2'd2;

    // Immediate format
    localparam logic [2:0] SEL_IMM_I = 3'd0;
    localparam logic [2:0] SEL_IMM_S = 3'd1;
    localparam logic [2:0] SEL_IMM_B = 3'd2;
    localparam logic [2:0] SEL_IMM_U = 3'd3;
    localparam logic [2:0] SEL_IMM_J = 3'd4;

    typedef enum logic [2:0] {
        BUSCA   = 3'd0,
        DECODE  = 3'd1,
        EXEC    = 3'd2,
        MEM     = 3'd3,
        ESCRITA = 3'd4,
        TRAP    = 3'd5
    } estado_t;

    // True for every opcode the FSM knows how to sequence
    function automatic logic opcode_conhecido(input logic [6:0] op);
        case (op)
            OP_LW, OP_SW, OP_ADD_SUB, OP_ADDI,
            OP_BRANCH, OP_JAL, OP_JALR, OP_AUIPC: opcode_conhecido = 1'b1;
            default:                              opcode_conhecido = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decodificador_desvio.sv
// Branch resolver: turns the branch funct3 and the ULA comparison flags
// into a single taken/not-taken decision.
module decodificador_desvio
    import riscv_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       flag_igual_i,
    input  logic       flag_menor_i,
    input  logic       flag_maior_igual_u_i,
    output logic       tomado_o
);

    // Select the comparison matching the branch kind; unknown codes never branch
    always_comb begin
        tomado_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  tomado_o = flag_igual_i;
            F3_BNE:  tomado_o = ~flag_igual_i;
            F3_BLT:  tomado_o = flag_menor_i;
            F3_BGE:  tomado_o = ~flag_menor_i;
            F3_BLTU: tomado_o = ~flag_maior_igual_u_i;
            F3_BGEU: tomado_o = flag_maior_igual_u_i;
            default: tomado_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control FSM for the RV64 core: fetch, decode, execute, memory
// and write-back sequencing, illegal-opcode trap and retired-instruction count.
// All enables are forced low while rst is high so an abandoned instruction
// can never write the register file, memory or PC.
module unidade_controle_multiciclo
    import riscv_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int CNT_W    = 32,
    parameter bit MEM_WAIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             flag_igual,
    input  logic             flag_menor,
    input  logic             flag_maior_igual_u,
    input  logic             mem_pronto,
    output logic             WeIR,
    output logic             WePC,
    output logic [1:0]       sel_pc,
    output logic [4:0]       Ra,
    output logic [4:0]       Rb,
    output logic [4:0]       Rw,
    output logic             WeR,
    output logic [1:0]       sel_wb,
    output logic             WeM,
    output logic             mem_req,
    output logic             subtraindo,
    output logic             imediato,
    output logic             sel_a_pc,
    output logic [2:0]       sel_imm,
    output logic             erro,
    output logic [CNT_W-1:0] retiradas
);

    // The counter wrap point is bounded by the datapath width
    localparam int CMP_W = (CNT_W < XLEN) ? CNT_W : XLEN;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'({CMP_W{1'b1}});

    estado_t          estado_q, estado_d;
    logic             erro_q, erro_d;
    logic [CNT_W-1:0] retiradas_q, retiradas_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       tomado;
    logic       mem_concluida;
    logic       fase_ula;
    logic       unused_instr;

    assign opcode        = instr[6:0];
    assign funct3        = instr[14:12];
    assign Ra            = instr[19:15];
    assign Rb            = instr[24:20];
    assign Rw            = instr[11:7];
    assign mem_concluida = !MEM_WAIT || mem_pronto;
    assign fase_ula      = (estado_q == EXEC) || (estado_q == MEM) || (estado_q == ESCRITA);
    assign unused_instr  = ^{instr[31], instr[29:25]};
    assign erro          = erro_q;
    assign retiradas     = retiradas_q;

    decodificador_desvio u_desvio (
        .funct3_i             (funct3),
        .flag_igual_i         (flag_igual),
        .flag_menor_i         (flag_menor),
        .flag_maior_igual_u_i (flag_maior_igual_u),
        .tomado_o             (tomado)
    );

    // State, sticky error flag and retired counter, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q    <= BUSCA;
            erro_q      <= 1'b0;
            retiradas_q <= '0;
        end else begin
            estado_q    <= estado_d;
            erro_q      <= erro_d;
            retiradas_q <= retiradas_d;
        end
    end

    // ULA operand controls, held from EXEC through write-back so the ULA result stays valid
    always_comb begin
        subtraindo = 1'b0;
        imediato   = 1'b0;
        sel_a_pc   = 1'b0;
        sel_imm    = SEL_IMM_I;
        if (!rst && fase_ula) begin
            case (opcode)
                OP_ADD_SUB: subtraindo = instr[30];
                OP_ADDI, OP_LW, OP_JALR: imediato = 1'b1;
                OP_SW: begin
                    imediato = 1'b1;
                    sel_imm  = SEL_IMM_S;
                end
                OP_AUIPC: begin
                    sel_a_pc = 1'b1;
                    imediato = 1'b1;
                    sel_imm  = SEL_IMM_U;
                end
                OP_BRANCH: sel_imm = SEL_IMM_B;
                OP_JAL:    sel_imm = SEL_IMM_J;
                default: ;
            endcase
        end
    end

    // Next state and datapath enables for each phase of the instruction
    always_comb begin
        estado_d = estado_q;
        erro_d   = erro_q;
        WeIR     = 1'b0;
        WePC     = 1'b0;
        sel_pc   = SEL_PC_MAIS4;
        WeR      = 1'b0;
        sel_wb   = SEL_WB_ULA;
        WeM      = 1'b0;
        mem_req  = 1'b0;
        if (!rst) begin
            case (estado_q)
                BUSCA: begin
                    WeIR     = 1'b1;
                    estado_d = DECODE;
                end
                DECODE: begin
                    if (opcode_conhecido(opcode)) begin
                        estado_d = EXEC;
                    end else begin
                        estado_d = TRAP;
                        erro_d   = 1'b1;
                    end
                end
                EXEC: begin
                    case (opcode)
                        OP_BRANCH: begin
                            WePC     = 1'b1;
                            sel_pc   = tomado ? SEL_PC_IMM : SEL_PC_MAIS4;
                            estado_d = BUSCA;
                        end
                        OP_LW, OP_SW: estado_d = MEM;
                        default:      estado_d = ESCRITA;
                    endcase
                end
                MEM: begin
                    mem_req = 1'b1;
                    WeM     = (opcode == OP_SW);
                    if (mem_concluida) begin
                        if (opcode == OP_SW) begin
                            WePC     = 1'b1;
                            estado_d = BUSCA;
                        end else begin
                            estado_d = ESCRITA;
                        end
                    end
                end
                ESCRITA: begin
                    WeR      = (Rw != 5'd0);
                    WePC     = 1'b1;
                    estado_d = BUSCA;
                    case (opcode)
                        OP_LW:   sel_wb = SEL_WB_MEM;
                        OP_JAL: begin
                            sel_wb = SEL_WB_PC4;
                            sel_pc = SEL_PC_IMM;
                        end
                        OP_JALR: begin
                            sel_wb = SEL_WB_PC4;
                            sel_pc = SEL_PC_ULA;
                        end
                        default: ;
                    endcase
                end
                TRAP:    estado_d = TRAP;
                default: estado_d = BUSCA;
            endcase
        end
    end

    // Count one retired instruction per PC update, wrapping at the counter limit
    always_comb begin
        retiradas_d = retiradas_q;
        if (WePC) begin
            retiradas_d = (retiradas_q == CNT_MAX) ? '0 : retiradas_q + 1'b1;
        end
    end

endmodule
